// File: rtl/exa_crosb_output_vc_arbiter_if.sv
// Request/grant bundle between the crossbar inputs and one output-port VC arbiter.
// master drives requests, credits and last; slave is the arbiter returning the grant.
interface exa_crosb_output_vc_arbiter_if #(
   parameter int prio_num  = 2,
   parameter int vc_num    = 3,
   parameter int input_num = 4
);
   localparam int vc_w = $clog2(prio_num * vc_num);

   logic [input_num-1:0]            req;
   logic [input_num-1:0][vc_w-1:0]  req_vc;
   logic [prio_num*vc_num-1:0]      credits;
   logic [input_num-1:0]            last;
   logic [input_num-1:0]            grant;
   logic [vc_w-1:0]                 grant_vc;
   logic                            busy;
   logic                            timeout;

   modport master (
      output req, req_vc, credits, last,
      input  grant, grant_vc, busy, timeout
   );

   modport slave (
      input  req, req_vc, credits, last,
      output grant, grant_vc, busy, timeout
   );
endinterface

// File: rtl/exa_crosb_output_vc_arbiter.sv
// Output-port arbiter: strict priority across classes, per-class round-robin across
// inputs, grant held until the winner's last beat or a watchdog release.
module exa_crosb_output_vc_arbiter #(
   parameter int prio_num      = 2,
   parameter int vc_num        = 3,
   parameter int input_num     = 4,
   parameter int max_pkt_beats = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   exa_crosb_output_vc_arbiter_if.slave  bus
);
   localparam int num_vc = prio_num * vc_num;
   localparam int vc_w   = $clog2(num_vc);
   localparam int in_w   = (input_num > 1) ? $clog2(input_num) : 1;
   localparam int cls_w  = (prio_num > 1) ? $clog2(prio_num) : 1;
   localparam int beat_w = $clog2(max_pkt_beats + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                            state;
   logic [in_w-1:0]                   owner;
   logic [beat_w-1:0]                 beats;
   logic [prio_num-1:0][in_w-1:0]     ptr;

   logic [input_num-1:0]              elig;
   logic [input_num-1:0][cls_w-1:0]   cls;
   logic                              any_elig;
   logic [cls_w-1:0]                  win_cls;
   logic [in_w-1:0]                   win_idx;
   int                                idx;

   always_comb begin
      elig     = '0;
      cls      = '0;
      any_elig = 1'b0;
      win_cls  = '0;
      win_idx  = '0;
      idx      = 0;
      // VC codes beyond the configured range never become eligible
      for (int i = 0; i < input_num; i++) begin
         if (int'(bus.req_vc[i]) < num_vc) begin
            cls[i]  = cls_w'(int'(bus.req_vc[i]) / vc_num);
            elig[i] = bus.req[i] & bus.credits[bus.req_vc[i]];
         end
      end
      for (int c = 0; c < prio_num; c++) begin
         for (int i = 0; i < input_num; i++) begin
            if (elig[i] && cls[i] == cls_w'(c)) begin
               any_elig = 1'b1;
               win_cls  = cls_w'(c);
            end
         end
      end
      // descending scan so the smallest offset from the class pointer wins
      for (int k = input_num - 1; k >= 0; k--) begin
         idx = (int'(ptr[win_cls]) + k) % input_num;
         if (elig[idx] && cls[idx] == win_cls)
            win_idx = in_w'(idx);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         owner        <= '0;
         beats        <= '0;
         ptr          <= '0;
         bus.grant    <= '0;
         bus.grant_vc <= '0;
         bus.busy     <= 1'b0;
         bus.timeout  <= 1'b0;
      end else begin
         bus.timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (any_elig) begin
                  state              <= BUSY;
                  owner              <= win_idx;
                  beats              <= '0;
                  ptr[win_cls]       <= (win_idx == in_w'(input_num - 1)) ? '0 : win_idx + 1'b1;
                  bus.grant          <= '0;
                  bus.grant[win_idx] <= 1'b1;
                  bus.grant_vc       <= bus.req_vc[win_idx];
                  bus.busy           <= 1'b1;
               end
            end
            BUSY: begin
               if (bus.last[owner] || beats == beat_w'(max_pkt_beats - 1)) begin
                  state        <= IDLE;
                  beats        <= '0;
                  bus.grant    <= '0;
                  bus.grant_vc <= '0;
                  bus.busy     <= 1'b0;
                  bus.timeout  <= ~bus.last[owner];
               end else if (beats != beat_w'(max_pkt_beats)) begin
                  beats <= beats + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_exa_crosb_output_vc_arbiter.sv
// Directed bench with a cycle-level reference model of the arbitration rules,
// compared every cycle, plus hand-computed expectations at key points.
module tb_exa_crosb_output_vc_arbiter;
   localparam int P = 2;
   localparam int V = 3;
   localparam int N = 4;
   localparam int MAXB = 32;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   exa_crosb_output_vc_arbiter_if #(.prio_num(P), .vc_num(V), .input_num(N)) bus ();

   exa_crosb_output_vc_arbiter #(
      .prio_num(P), .vc_num(V), .input_num(N), .max_pkt_beats(MAXB)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: state after each rising edge
   bit m_valid = 0;
   bit m_busy, m_to;
   int m_win, m_vc, m_beats;
   int m_ptr[P];

   function automatic bit model_elig(int i);
      int vc;
      vc = int'(bus.req_vc[i]);
      return bus.req[i] && vc < P * V && bus.credits[vc];
   endfunction

   always @(posedge clk) begin
      int best, idx, vc;
      bit found;
      if (reset) begin
         m_busy = 0; m_to = 0; m_win = 0; m_vc = 0; m_beats = 0;
         for (int c = 0; c < P; c++) m_ptr[c] = 0;
      end else if (m_busy) begin
         m_to = 0;
         if (bus.last[m_win]) begin
            m_busy = 0;
         end else if (m_beats == MAXB) begin
            m_busy = 0;
            m_to = 1;
         end else begin
            m_beats++;
         end
      end else begin
         m_to = 0;
         best = -1;
         for (int i = 0; i < N; i++)
            if (model_elig(i) && int'(bus.req_vc[i]) / V > best) best = int'(bus.req_vc[i]) / V;
         if (best >= 0) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
               idx = (m_ptr[best] + k) % N;
               vc = int'(bus.req_vc[idx]);
               if (!found && model_elig(idx) && vc / V == best) begin
                  found = 1;
                  m_win = idx;
                  m_vc = vc;
               end
            end
            m_busy = 1;
            m_beats = 1;
            m_ptr[best] = (m_win + 1) % N;
         end
      end
      m_valid = 1;
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("model_grant", int'(bus.grant), m_busy ? (1 << m_win) : 0);
         check("model_grant_vc", int'(bus.grant_vc), m_busy ? m_vc : 0);
         check("model_busy", int'(bus.busy), int'(m_busy));
         check("model_timeout", int'(bus.timeout), int'(m_to));
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   int order[5] = '{0, 1, 2, 3, 0};

   initial begin
      bus.req = '0;
      bus.req_vc = '0;
      bus.credits = '1;
      bus.last = '0;
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      check("reset_grant", int'(bus.grant), 0);
      check("reset_busy", int'(bus.busy), 0);
      check("reset_timeout", int'(bus.timeout), 0);

      // single request
      bus.req[2] = 1'b1; bus.req_vc[2] = 3'd1;
      step(1);
      check("single_grant", int'(bus.grant), 4);
      check("single_vc", int'(bus.grant_vc), 1);
      bus.req[2] = 1'b0; bus.last[2] = 1'b1;
      step(1);
      bus.last = '0;
      check("single_release", int'(bus.grant), 0);
      check("single_ptr0", m_ptr[0], 3);

      // priority
      bus.req[0] = 1'b1; bus.req_vc[0] = 3'd0;
      bus.req[3] = 1'b1; bus.req_vc[3] = 3'd4;
      step(1);
      check("prio_first", int'(bus.grant), 8);
      check("prio_first_vc", int'(bus.grant_vc), 4);
      bus.req[3] = 1'b0; bus.last[3] = 1'b1;
      step(1);
      bus.last = '0;
      check("prio_bubble", int'(bus.busy), 0);
      step(1);
      check("prio_second", int'(bus.grant), 1);
      bus.req[0] = 1'b0; bus.last[0] = 1'b1;
      step(1);
      bus.last = '0;

      // round-robin wrap from a cleared pointer
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      bus.req = 4'hf;
      for (int i = 0; i < N; i++) bus.req_vc[i] = 3'(i % 3);
      step(1);
      for (int g = 0; g < 5; g++) begin
         check("rr_grant", int'(bus.grant), 1 << order[g]);
         step(16);
         check("rr_held", int'(bus.grant), 1 << order[g]);
         bus.last[order[g]] = 1'b1;
         if (g == 4) bus.req = '0;
         step(1);
         bus.last = '0;
         check("rr_gap", int'(bus.busy), 0);
         step(1);
      end

      // credits
      bus.credits = 6'b111011;
      bus.req[1] = 1'b1; bus.req_vc[1] = 3'd2;
      bus.req[2] = 1'b1; bus.req_vc[2] = 3'd0;
      step(1);
      check("cred_grant", int'(bus.grant), 4);
      bus.req[2] = 1'b0;
      bus.credits[0] = 1'b0;
      step(3);
      check("cred_drop_held", int'(bus.grant), 4);
      bus.last[2] = 1'b1;
      step(1);
      bus.last = '0;
      step(2);
      check("cred_blocked", int'(bus.busy), 0);
      bus.credits = '1;
      step(1);
      check("cred_unblocked", int'(bus.grant), 2);
      check("cred_unblocked_vc", int'(bus.grant_vc), 2);
      bus.req[1] = 1'b0; bus.last[1] = 1'b1;
      step(1);
      bus.last = '0;

      // watchdog
      bus.req[0] = 1'b1; bus.req_vc[0] = 3'd3;
      step(1);
      check("wd_grant", int'(bus.grant), 1);
      bus.req[0] = 1'b0;
      step(31);
      check("wd_last_cycle", int'(bus.grant), 1);
      check("wd_no_early", int'(bus.timeout), 0);
      step(1);
      check("wd_pulse", int'(bus.timeout), 1);
      check("wd_grant_clear", int'(bus.grant), 0);
      step(1);
      check("wd_pulse_end", int'(bus.timeout), 0);
      bus.req[0] = 1'b1;
      step(1);
      bus.req[0] = 1'b0;
      step(31);
      bus.last[0] = 1'b1;
      step(1);
      bus.last = '0;
      check("wd_coincident", int'(bus.timeout), 0);
      check("wd_coincident_grant", int'(bus.grant), 0);

      // reset mid-grant
      step(1);
      bus.req[1] = 1'b1; bus.req_vc[1] = 3'd5;
      step(1);
      check("rst_pre", int'(bus.grant), 2);
      step(3);
      reset = 1'b1;
      step(1);
      check("rst_grant", int'(bus.grant), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_timeout", int'(bus.timeout), 0);
      check("rst_ptr1", m_ptr[1], 0);
      reset = 1'b0;
      step(1);
      check("rst_regrant", int'(bus.grant), 2);
      check("rst_regrant_vc", int'(bus.grant_vc), 5);
      bus.req[1] = 1'b0; bus.last[1] = 1'b1;
      step(1);
      bus.last = '0;
      step(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
